// File: rtl/conv_pe_lb.sv
// Streaming KxK signed convolution PE: line-buffer window, 2-stage MAC, result 2 cycles after completing pixel.
// No output backpressure; CONV_PE_RELU_EN clamps negative sums to zero.
module conv_pe_lb #(
   parameter int DW    = 9,
   parameter int K     = 3,
   parameter int IMG_W = 10,
   parameter int IMG_H = 10,
   parameter int ACC_W = 2*DW + $clog2(K*K)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             w_start,
   input  logic             w_valid,
   output logic             w_ready,
   input  logic [DW-1:0]    w_data,
   input  logic             pix_valid,
   output logic             pix_ready,
   input  logic [DW-1:0]    pix_data,
   output logic             out_valid,
   output logic [ACC_W-1:0] out_data,
   output logic             out_last
);

   localparam int NT  = K*K;
   localparam int WCW = $clog2(NT);
   localparam int CW  = $clog2(IMG_W);
   localparam int RW  = $clog2(IMG_H);
   localparam int PW  = 2*DW;

   typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
   state_t state, state_nxt;

   logic [WCW-1:0]          w_cnt;
   logic [CW-1:0]           col;
   logic [RW-1:0]           row;
   logic signed [DW-1:0]    wt      [NT];
   logic signed [DW-1:0]    lb      [K-1][IMG_W];
   logic signed [DW-1:0]    win     [K][K-1];
   logic signed [DW-1:0]    col_vec [K];
   logic signed [DW-1:0]    nwin    [K][K];
   logic signed [PW-1:0]    prod    [NT];
   logic signed [ACC_W-1:0] sum, sum_q;
   logic                    v1, last1;
   logic                    w_hs, pix_hs, w_last_word, win_done, frame_end;

   // w_start overrides any handshake in the same cycle
   assign w_ready     = (state == LOAD);
   assign pix_ready   = (state == RUN);
   assign w_hs        = w_valid & w_ready & ~w_start;
   assign pix_hs      = pix_valid & pix_ready & ~w_start;
   assign w_last_word = (w_cnt == WCW'(NT-1));
   assign frame_end   = (row == RW'(IMG_H-1)) && (col == CW'(IMG_W-1));
   assign win_done    = pix_hs && (row >= RW'(K-1)) && (col >= CW'(K-1));

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (w_start) state_nxt = LOAD;
         LOAD:    if (w_start) state_nxt = LOAD;
                  else if (w_hs && w_last_word) state_nxt = RUN;
         RUN:     if (w_start) state_nxt = LOAD;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         w_cnt     <= '0;
         col       <= '0;
         row       <= '0;
         v1        <= 1'b0;
         last1     <= 1'b0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_data  <= '0;
         for (int i = 0; i < NT; i++) wt[i] <= '0;
      end else begin
         state <= state_nxt;
         if (w_start) begin
            w_cnt     <= '0;
            col       <= '0;
            row       <= '0;
            v1        <= 1'b0;
            last1     <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end else begin
            if (w_hs) begin
               wt[w_cnt] <= w_data;
               w_cnt     <= w_last_word ? '0 : w_cnt + 1'b1;
            end
            if (pix_hs) begin
               if (col == CW'(IMG_W-1)) begin
                  col <= '0;
                  row <= (row == RW'(IMG_H-1)) ? '0 : row + 1'b1;
               end else begin
                  col <= col + 1'b1;
               end
            end
            v1        <= win_done;
            last1     <= win_done & frame_end;
            out_valid <= v1;
            out_last  <= v1 & last1;
            if (v1) out_data <= sum_q;
         end
      end
   end

   // Column entering the window: oldest line-buffer row on top, live pixel at the bottom
   always_comb begin
      col_vec[K-1] = pix_data;
      for (int j = 0; j < K-1; j++) col_vec[K-2-j] = lb[j][col];
      for (int r = 0; r < K; r++) begin
         for (int c = 0; c < K-1; c++) nwin[r][c] = win[r][c];
         nwin[r][K-1] = col_vec[r];
      end
   end

   always_ff @(posedge clk) begin
      if (pix_hs) begin
         lb[0][col] <= pix_data;
         for (int j = 1; j < K-1; j++) lb[j][col] <= lb[j-1][col];
         for (int r = 0; r < K; r++)
            for (int c = 0; c < K-1; c++) win[r][c] <= nwin[r][c+1];
      end
      if (win_done) begin
         for (int t = 0; t < NT; t++) prod[t] <= PW'(nwin[t / K][t % K]) * PW'(wt[t]);
      end
   end

   always_comb begin
      sum = '0;
      for (int t = 0; t < NT; t++) sum = sum + ACC_W'(prod[t]);
      sum_q = sum;
`ifdef CONV_PE_RELU_EN
      if (sum[ACC_W-1]) sum_q = '0;
`else
`endif
   end

endmodule

// File: doc/conv_pe_lb.md
Name: conv_pe_lb

Overview:
- Streaming KxK 2-D convolution processing element; successor to the fixed 3x3 shift-register PE.
- Generalised in kernel size, data width, image width and height.
- Features: line-buffer window generator, explicit weight-load and pixel valid/ready handshakes, pipelined signed MAC with valid/last output.
- Sits between the feature-map reader and the accumulation/pooling stage; one instance per input channel.

Parameters:
- DW, 9, signed pixel and weight width.
- K, 3, kernel size (KxK window); legal range 2..5.
- IMG_W, 10, image width in pixels; IMG_W >= K.
- IMG_H, 10, image height in pixels; IMG_H >= K.
- ACC_W, 2*DW+$clog2(K*K), output accumulator width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- w_start  in  1  one-cycle pulse: begin a new weight load.
- w_valid  in  1  weight word valid.
- w_ready  out  1  PE accepts weight words.
- w_data  in  DW  signed weight, raster order; index 0 = top-left tap.
- pix_valid  in  1  pixel valid.
- pix_ready  out  1  PE accepts pixels.
- pix_data  in  DW  signed pixel, raster order.
- out_valid  out  1  out_data holds a complete window result.
- out_data  out  ACC_W  signed convolution result.
- out_last  out  1  marks the bottom-right window of the frame.

Behaviour:
- Reset and clock: rst_n is a synchronous, active-low reset; clock is clk. On reset:
  - state = IDLE; all counters = 0; pipeline valid bits = 0.
  - w_ready = 0, pix_ready = 0, out_valid = 0, out_last = 0, out_data = 0.
  - Weight registers cleared to 0.
- States:
  - IDLE: no weights. w_start -> LOAD.
  - LOAD: w_ready = 1. Weight word stored at w_cnt on each w_valid & w_ready cycle. After word K*K-1 -> RUN; w_ready drops the next cycle.
  - RUN: pix_ready = 1. w_start -> LOAD.
- Weight register updates: only on the w_valid & w_ready handshake. A zero-valued weight is a legal weight.
- w_start in any state:
  - Clears w_cnt, col, row and the pipeline valid bits; aborts any partial frame.
  - Line-buffer contents are left undefined.
  - w_start and w_valid in the same cycle: w_start wins; that weight word is dropped.
- Pixel accept: pix_valid & pix_ready.
  - Pixel written to line buffers ((K-1) rows x IMG_W) and the KxK window registers.
  - col increments and wraps at IMG_W-1; row increments on col wrap and wraps at IMG_H-1.
  - Frame end (row=IMG_H-1, col=IMG_W-1) returns both counters to 0; the next pixel starts a new frame with no gap.
- Window valid: the accepted pixel completes a window when row >= K-1 and col >= K-1. This yields (IMG_W-K+1)*(IMG_H-K+1) results per frame. No padding; stride 1.
- Arithmetic:
  - Stage 1: K*K signed DWxDW products, registered.
  - Stage 2: adder tree sum, sign-extended to ACC_W, registered.
  - No saturation; ACC_W is sized so overflow cannot occur.
- Latency and outputs:
  - out_valid asserts exactly 2 cycles after the completing pixel beat; it is a one-cycle pulse per result.
  - out_data holds its value when out_valid = 0.
  - No output backpressure; the downstream stage must accept every pulse.
- Pixel gaps: pix_valid low stalls the counters only; results already in the pipeline still emerge on schedule.
- out_last: asserted with the result of the window completed at row=IMG_H-1, col=IMG_W-1.
- Reset mid-frame: all results in flight are discarded; no out_valid after reset until a new weight load and frame.

Optional Feature:
- Macro: CONV_PE_RELU_EN.
- Defined: stage 2 clamps negative sums to 0 before registering; out_valid and out_last timing unchanged.
- Undefined: raw signed sum is output.

Test Plan:
- Weight load: reset, w_start, 9 words 1..9 with w_valid gaps -> w_ready high for exactly the 9 accepts; RUN entered; pix_ready = 1 the cycle after word 9.
- Sums: IMG_W=IMG_H=4, K=3, all weights 1, pixels 1..16 back-to-back -> 4 pulses 54, 63, 90, 99; first pulse 2 cycles after pixel 11; out_last only with 99.
- Signs: weights all -1, pixels all 100 -> results -900; with CONV_PE_RELU_EN -> results 0.
- Stalls: same frame as the sums test with pix_valid toggling every other cycle -> identical values and order; each pulse 2 cycles after its completing pixel.
- Abort: w_start after pixel 6, reload all-1 weights, resend 1..16 -> only 54, 63, 90, 99; no stale output.
- Reset: rst_n low for 1 cycle during the RUN frame -> all outputs 0 next cycle; state IDLE; pix_ready = 0.
